// File: rtl/sensor_sampler_if.sv
// ADC conversion handshake between the sampler (master) and the sensor ADC (slave).
interface sensor_sampler_if #(
    parameter int unsigned ADC_W = 10
);
    logic             adc_start;
    logic             adc_done;
    logic [ADC_W-1:0] adc_data;

    modport master (output adc_start, input adc_done, input adc_data);
    modport slave  (input adc_start, output adc_done, output adc_data);
endinterface

// File: rtl/sensor_sampler.sv
// Sensor acquisition controller: sequences ADC conversions, averages bursts, publishes an 8-bit result.
// Optional conversion timeout with sticky error flag: define SENS_TIMEOUT_EN.
module sensor_sampler #(
    parameter int unsigned ADC_W    = 10,
    parameter int unsigned BASE_DIV = 1000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              sens_mode,
    sensor_sampler_if.master        adc,
    output logic [7:0]              sens_data_o,
    output logic                    sample_valid,
    output logic                    busy,
    output logic                    sens_err
);
    localparam int unsigned ACC_W  = ADC_W + 3;
    localparam int unsigned WCNT_W = $clog2((BASE_DIV << 7) + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_CONV  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] M_OFF    = 2'b00;
    localparam logic [1:0] M_SINGLE = 2'b01;
    localparam logic [1:0] M_AVG    = 2'b11;

    if (ADC_W < 8 || BASE_DIV < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("sensor_sampler: ADC_W must be >= 8, BASE_DIV and TIMEOUT >= 1");
    end

    logic [2:0]        state_q, state_d;
    logic [1:0]        mode_prev_q, mode_prev_d;
    logic [1:0]        mode_sh_q, mode_sh_d;
    logic [1:0]        avg_sh_q, avg_sh_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WCNT_W-1:0] wait_q, wait_d;
    logic              adc_start_q, adc_start_d;
    logic [7:0]        sens_data_q, sens_data_d;
    logic              sample_valid_q, sample_valid_d;
    logic              busy_q, busy_d;
    logic              sens_err_q, sens_err_d;

    logic [1:0]        live_mode;
    logic [WCNT_W-1:0] wait_period;
    logic [3:0]        burst_n;
    logic [7:0]        result;
    logic              reserved_unused;

    assign live_mode       = sens_mode[1:0];
    assign wait_period     = WCNT_W'(BASE_DIV) << sens_mode[4:2];
    assign burst_n         = 4'd1 << avg_sh_q;
    // avg_sh is zero outside averaged mode, so the shift is a no-op there
    assign result          = 8'((acc_q >> avg_sh_q) >> (ADC_W - 8));
    assign reserved_unused = sens_mode[7];

`ifdef SENS_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        mode_prev_d    = live_mode;
        mode_sh_d      = mode_sh_q;
        avg_sh_d       = avg_sh_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        wait_d         = wait_q;
        sens_data_d    = sens_data_q;
        sample_valid_d = 1'b0;
        sens_err_d     = sens_err_q;
`ifdef SENS_TIMEOUT_EN
        tcnt_d         = tcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (live_mode[1] || (live_mode == M_SINGLE && mode_prev_q != M_SINGLE))
                    state_d = S_START;
            end
            S_START: begin
                if (cnt_q == 4'd0) begin
                    mode_sh_d = live_mode;
                    avg_sh_d  = (live_mode == M_AVG) ? sens_mode[6:5] : 2'd0;
                end
`ifdef SENS_TIMEOUT_EN
                tcnt_d  = '0;
`endif
                state_d = S_CONV;
            end
            S_CONV: begin
                if (adc.adc_done) begin
                    acc_d   = acc_q + ACC_W'(adc.adc_data);
                    cnt_d   = cnt_q + 4'd1;
                    state_d = (cnt_q + 4'd1 == burst_n) ? S_DONE : S_START;
                end
`ifdef SENS_TIMEOUT_EN
                else if (tcnt_q == TCNT_W'(TIMEOUT)) begin
                    sens_err_d = 1'b1;
                    acc_d      = '0;
                    cnt_d      = '0;
                    wait_d     = '0;
                    state_d    = (mode_sh_q == M_SINGLE) ? S_IDLE : S_WAIT;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
`endif
            end
            S_DONE: begin
                sens_data_d    = result;
                sample_valid_d = 1'b1;
                acc_d          = '0;
                cnt_d          = '0;
                wait_d         = '0;
                state_d        = (mode_sh_q == M_SINGLE) ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                // Entry cycle plus P counted cycles gives P+1 cycles from sample_valid to adc_start
                if (wait_q == wait_period) state_d = S_START;
                else                       wait_d  = wait_q + WCNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        if (live_mode == M_OFF) begin
            state_d        = S_IDLE;
            acc_d          = '0;
            cnt_d          = '0;
            sens_data_d    = sens_data_q;
            sample_valid_d = 1'b0;
            sens_err_d     = 1'b0;
        end

        adc_start_d = (state_d == S_START);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            mode_prev_q    <= '0;
            mode_sh_q      <= '0;
            avg_sh_q       <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
            wait_q         <= '0;
            adc_start_q    <= 1'b0;
            sens_data_q    <= '0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            sens_err_q     <= 1'b0;
`ifdef SENS_TIMEOUT_EN
            tcnt_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            mode_prev_q    <= mode_prev_d;
            mode_sh_q      <= mode_sh_d;
            avg_sh_q       <= avg_sh_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            wait_q         <= wait_d;
            adc_start_q    <= adc_start_d;
            sens_data_q    <= sens_data_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
            sens_err_q     <= sens_err_d;
`ifdef SENS_TIMEOUT_EN
            tcnt_q         <= tcnt_d;
`endif
        end
    end

    assign adc.adc_start = adc_start_q;
    assign sens_data_o   = sens_data_q;
    assign sample_valid  = sample_valid_q;
    assign busy          = busy_q;
    assign sens_err      = sens_err_q;
endmodule

// File: tb/tb_sensor_sampler.sv
// Self-checking bench for sensor_sampler: directed scenarios plus randomized mode/ADC traffic
// compared every cycle against a transaction-level reference model.
module tb_sensor_sampler;
    localparam int unsigned ADC_W    = 10;
    localparam int unsigned BASE_DIV = 4;
    localparam int unsigned TIMEOUT  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sens_mode = 8'h00;
    logic [7:0] sens_data_o;
    logic       sample_valid, busy, sens_err;

    sensor_sampler_if #(.ADC_W(ADC_W)) adc_if();

    sensor_sampler #(.ADC_W(ADC_W), .BASE_DIV(BASE_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sens_mode    (sens_mode),
        .adc          (adc_if),
        .sens_data_o  (sens_data_o),
        .sample_valid (sample_valid),
        .busy         (busy),
        .sens_err     (sens_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int n_start = 0;
    int n_valid = 0;
    int st_q[$];
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ADC responder: answers each adc_start after a latency, optionally with spurious strobes
    int  rem = 0;
    int  resp_lat = 3;
    bit  resp_en = 1'b1, resp_rand = 1'b0, resp_spur = 1'b0;
    logic [ADC_W-1:0] resp_q[$];

    always @(negedge clk) begin
        adc_if.adc_done = 1'b0;
        if (adc_if.adc_start === 1'b1) begin
            rem = resp_en ? (resp_rand ? int'($urandom_range(1, 6)) : resp_lat) : 0;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                adc_if.adc_done = 1'b1;
                adc_if.adc_data = (resp_q.size() > 0) ? resp_q.pop_front() : ADC_W'($urandom);
            end
        end else if (resp_spur && $urandom_range(0, 7) == 0) begin
            adc_if.adc_done = 1'b1;
            adc_if.adc_data = ADC_W'($urandom);
        end
    end

    // Reference model: phases of an acquisition, samples kept as a list and averaged by division
    localparam int PH_OFF = 0, PH_REQ = 1, PH_CONV = 2, PH_PUB = 3, PH_GAP = 4;
    int ph = PH_OFF;
    int samples[$];
    int burst_n = 1, burst_mode = 0, gap_left = 0, prev_mode = 0, conv_age = 0;
    bit e_start = 1'b0, e_valid = 1'b0, e_busy = 1'b0, e_err = 1'b0;
    logic [7:0] e_data = 8'h00;

    always @(posedge clk) begin : ref_model
        int live, sum, period;
        live   = int'(sens_mode[1:0]);
        period = int'(BASE_DIV) << sens_mode[4:2];
        e_valid = 1'b0;
        if (!rst_n) begin
            ph = PH_OFF; samples.delete(); prev_mode = 0; e_data = 8'h00; e_err = 1'b0;
        end else begin
            if (live == 0) begin
                ph = PH_OFF; samples.delete(); e_err = 1'b0;
            end else begin
                case (ph)
                    PH_OFF: if (live >= 2 || (live == 1 && prev_mode != 1)) ph = PH_REQ;
                    PH_REQ: begin
                        if (samples.size() == 0) begin
                            burst_mode = live;
                            burst_n    = (live == 3) ? (1 << sens_mode[6:5]) : 1;
                        end
                        conv_age = 0;
                        ph = PH_CONV;
                    end
                    PH_CONV: begin
                        if (adc_if.adc_done) begin
                            samples.push_back(int'(adc_if.adc_data));
                            ph = (samples.size() == burst_n) ? PH_PUB : PH_REQ;
                        end
`ifdef SENS_TIMEOUT_EN
                        else if (conv_age == int'(TIMEOUT)) begin
                            e_err = 1'b1;
                            samples.delete();
                            if (burst_mode == 1) ph = PH_OFF;
                            else begin ph = PH_GAP; gap_left = period + 1; end
                        end else conv_age++;
`endif
                    end
                    PH_PUB: begin
                        sum = 0;
                        foreach (samples[i]) sum += samples[i];
                        e_data  = 8'((sum / burst_n) >> (ADC_W - 8));
                        e_valid = 1'b1;
                        samples.delete();
                        if (burst_mode == 1) ph = PH_OFF;
                        else begin ph = PH_GAP; gap_left = period + 1; end
                    end
                    PH_GAP: begin
                        gap_left--;
                        if (gap_left == 0) ph = PH_REQ;
                    end
                    default: ph = PH_OFF;
                endcase
            end
            prev_mode = live;
        end
        e_start = (ph == PH_REQ);
        e_busy  = (ph != PH_OFF);
    end

    // Per-cycle comparison against the model, plus event bookkeeping
    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            chk("adc_start",    32'(adc_if.adc_start), 32'(e_start));
            chk("sample_valid", 32'(sample_valid),     32'(e_valid));
            chk("busy",         32'(busy),             32'(e_busy));
            chk("sens_err",     32'(sens_err),         32'(e_err));
            chk("sens_data_o",  32'(sens_data_o),      32'(e_data));
        end
        if (adc_if.adc_start === 1'b1) begin n_start++; st_q.push_back(cyc); end
        if (sample_valid === 1'b1) n_valid++;
    end

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_starts(input int target, input int budget, input string nm);
        int k = 0;
        while (st_q.size() < target && k < budget) begin tick(1); k++; end
        if (st_q.size() < target) chk(nm, 32'(st_q.size()), 32'(target));
    endtask

    task automatic wait_valid(input int target, input int budget, input string nm);
        int k = 0;
        while (n_valid < target && k < budget) begin tick(1); k++; end
        if (n_valid < target) chk(nm, 32'(n_valid), 32'(target));
    endtask

    initial begin
        int s0, v0;
        adc_if.adc_done = 1'b0;
        adc_if.adc_data = '0;
        tick(1);
        chk_en = 1'b1;
        tick(2);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_data", 32'(sens_data_o), 32'd0);
        chk("reset_start", 32'(adc_if.adc_start), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Single shot, edge-detected re-arm
        s0 = n_start; v0 = n_valid;
        resp_lat = 3; resp_q.push_back(10'h3FC);
        sens_mode = 8'h01;
        tick(20);
        chk("single_starts", 32'(n_start - s0), 32'd1);
        chk("single_valid", 32'(n_valid - v0), 32'd1);
        chk("single_data", 32'(sens_data_o), 32'hFF);
        chk("single_idle", 32'(busy), 32'd0);
        tick(20);
        chk("hold01_nostart", 32'(n_start - s0), 32'd1);
        sens_mode = 8'h00; tick(1);
        resp_q.push_back(10'h100);
        sens_mode = 8'h01;
        tick(20);
        chk("rearm_starts", 32'(n_start - s0), 32'd2);
        chk("rearm_data", 32'(sens_data_o), 32'h40);

        // Continuous, RATE=1 (P=8), latency 3
        for (int i = 0; i < 6; i++) resp_q.push_back(10'h200);
        st_q.delete();
        sens_mode = 8'h06;
        wait_starts(5, 200, "cont_wait_starts");
        if (st_q.size() >= 5)
            for (int i = 1; i < 5; i++) chk("cont_spacing", 32'(st_q[i] - st_q[i-1]), 32'd14);
        chk("cont_data", 32'(sens_data_o), 32'h80);

        // Abort in CONV; the late adc_done must be ignored
        tick(1);
        v0 = n_valid;
        sens_mode = 8'h00;
        tick(6);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(n_valid - v0), 32'd0);
        chk("abort_data", 32'(sens_data_o), 32'h80);
        resp_q.delete();

        // Averaged continuous, N=4
        st_q.delete(); s0 = n_start; v0 = n_valid;
        resp_q.push_back(10'd100); resp_q.push_back(10'd200);
        resp_q.push_back(10'd300); resp_q.push_back(10'd400);
        sens_mode = 8'h43;
        wait_valid(v0 + 1, 200, "avg_wait_valid");
        chk("avg_starts", 32'(n_start - s0), 32'd4);
        chk("avg_data", 32'(sens_data_o), 32'h3E);
        chk("avg_model_pin", 32'(e_data), 32'h3E);
        if (st_q.size() >= 4)
            for (int i = 1; i < 4; i++) chk("avg_backtoback", 32'(st_q[i] - st_q[i-1]), 32'd4);
        sens_mode = 8'h00; tick(2);

        // ADC never answers
        resp_en = 1'b0; s0 = n_start;
        sens_mode = 8'h02;
        tick(40);
`ifdef SENS_TIMEOUT_EN
        chk("timeout_err", 32'(sens_err), 32'd1);
        sens_mode = 8'h00; tick(2);
        chk("timeout_err_clear", 32'(sens_err), 32'd0);
`else
        chk("hang_starts", 32'(n_start - s0), 32'd1);
        chk("hang_busy", 32'(busy), 32'd1);
        chk("hang_err", 32'(sens_err), 32'd0);
        sens_mode = 8'h00; tick(2);
        chk("hang_abort_idle", 32'(busy), 32'd0);
`endif
        resp_en = 1'b1;

        // Synchronous reset after 3 of 8 samples
        resp_lat = 2; st_q.delete();
        sens_mode = 8'h63;
        wait_starts(4, 100, "rst_wait_starts");
        rst_n = 1'b0;
        tick(1);
        chk("rst_start", 32'(adc_if.adc_start), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(sens_err), 32'd0);
        chk("rst_data", 32'(sens_data_o), 32'd0);
        rst_n = 1'b1;
        s0 = n_start; v0 = n_valid;
        wait_valid(v0 + 1, 300, "rst_wait_valid");
        chk("rst_restart_starts", 32'(n_start - s0), 32'd8);
        sens_mode = 8'h00; tick(2);

        // Randomized sessions: RATE fixed per session, MODE/AVG/reserved bit random
        resp_rand = 1'b1; resp_spur = 1'b1;
        for (int s = 0; s < 14; s++) begin
            logic [2:0] rate;
            rate = 3'($urandom_range(0, 3));
            sens_mode = {3'b000, rate, 2'b00};
            tick(2);
            for (int k = 0; k < 6; k++) begin
                sens_mode = {1'($urandom), 2'($urandom), rate, 2'($urandom)};
                tick(int'($urandom_range(10, 150)));
            end
        end

        sens_mode = 8'h00;
        tick(3);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
